// File: rtl/counter_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_share_pkg
//  Description : Shared types and constants for the counter-share arbiter:
//                FSM state encoding, default sizes and an index-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package counter_share_pkg;

    localparam int C_DEFAULT_NREQ = 4;
    localparam int C_DEFAULT_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_share_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : counter_share_arbiter_if
//  Description : Request/grant/counter bundle between the timing clients
//                (master) and the counter-share arbiter (slave).
//                  req    NREQ     per-requester request level
//                  len    NREQ*W   terminal counts, requester i at [i*W +: W]
//                  gnt    NREQ     one-hot grant
//                  gnt_id IW       granted requester index
//                  busy   1        counter owned
//                  done   1        terminal-count pulse
//                  cout   W        live counter value
//  Revision    : 1.0  initial release
// ============================================================================
interface counter_share_arbiter_if
    import counter_share_pkg::*;
#(
    parameter int NREQ = C_DEFAULT_NREQ,
    parameter int W    = C_DEFAULT_W
);
    localparam int IW = idx_w(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] len;
    logic [NREQ-1:0]   gnt;
    logic [IW-1:0]     gnt_id;
    logic              busy;
    logic              done;
    logic [W-1:0]      cout;

    modport master (
        output req, len,
        input  gnt, gnt_id, busy, done, cout
    );

    modport slave (
        input  req, len,
        output gnt, gnt_id, busy, done, cout
    );

endinterface

`default_nettype wire

// File: rtl/counter_share_arbiter_cnt_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_rr_pick
//  Description : Combinational round-robin pick. Returns the first set
//                request at or after the pointer, wrapping NREQ-1 -> 0.
//                  i_req   NREQ        request vector
//                  i_ptr   clog2(NREQ) search start position
//                  o_valid 1           any request set
//                  o_index clog2(NREQ) winning requester
//  Revision    : 1.0  initial release
// ============================================================================
module cnt_rr_pick #(
    parameter int NREQ = 4
) (
    input  wire logic [NREQ-1:0]         i_req,
    input  wire logic [$clog2(NREQ)-1:0] i_ptr,
    output logic                         o_valid,
    output logic [$clog2(NREQ)-1:0]      o_index
);
    localparam int IW = $clog2(NREQ);

    // Scan offsets from farthest to nearest so the nearest hit is the last
    // one written and therefore wins.
    always_comb begin : p_pick
        logic [IW-1:0] w_pos;
        o_valid = 1'b0;
        o_index = '0;
        w_pos   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = IW'((int'(i_ptr) + k) % NREQ);
            if (i_req[w_pos]) begin
                o_valid = 1'b1;
                o_index = w_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/counter_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : counter_share_arbiter
//  Description : Shares one W-bit up-counter between NREQ requesters. A
//                round-robin pick grants the counter, which runs from 0 up to
//                the winner's terminal count, pulses done, then releases.
//                  clk    rising-edge clock
//                  reset  asynchronous, active-low
//                  bus    counter_share_arbiter_if slave modport
//  Revision    : 1.0  initial release
// ============================================================================
module counter_share_arbiter
    import counter_share_pkg::*;
#(
    parameter int NREQ = C_DEFAULT_NREQ,
    parameter int W    = C_DEFAULT_W
) (
    input  wire logic              clk,
    input  wire logic              reset,
    counter_share_arbiter_if.slave bus
);
    localparam int IW = idx_w(NREQ);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     gnt_id_q, gnt_id_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [W-1:0]      cout_q, cout_d;
    logic [W-1:0]      len_q, len_d;

    logic              w_pick_valid;
    logic [IW-1:0]     w_pick_idx;
    logic [IW-1:0]     w_ptr_after;

    cnt_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req   (bus.req),
        .i_ptr   (ptr_q),
        .o_valid (w_pick_valid),
        .o_index (w_pick_idx)
    );

    // The requester after the current owner starts the next search, which
    // keeps a finished or aborted owner from winning again while others wait.
    assign w_ptr_after = (gnt_id_q == IW'(NREQ - 1)) ? '0 : gnt_id_q + IW'(1);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        done_d   = done_q;
        cout_d   = cout_q;
        len_d    = len_q;

        case (state_q)
            IDLE: begin
                if (w_pick_valid) begin
                    state_d  = COUNT;
                    gnt_d    = NREQ'(1) << w_pick_idx;
                    gnt_id_d = w_pick_idx;
                    busy_d   = 1'b1;
                    len_d    = bus.len[w_pick_idx*W +: W];
                    cout_d   = '0;
                end
            end

            COUNT: begin
                // A dropped request wins over a simultaneous terminal match.
                if (!bus.req[gnt_id_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    cout_d  = '0;
                    ptr_d   = w_ptr_after;
                end else if (cout_q == len_q) begin
                    // Match is tested before increment, so cout never wraps
                    // even for an all-ones terminal count.
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cout_d = cout_q + W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                gnt_d   = '0;
                busy_d  = 1'b0;
                cout_d  = '0;
                ptr_d   = w_ptr_after;
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                cout_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
            len_q    <= len_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.cout   = cout_q;

endmodule

`default_nettype wire
